// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    localparam int                     FETCH_PKT_W      = 64;
    localparam logic [FETCH_PKT_W-1:0] NOP_PKT          = '0;
    localparam logic [31:0]            DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/ack bus between the fetch stage (master) and memory (slave).
interface instr_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_ack_i;
    logic [31:0]       imem_data_i;

    modport master (output imem_req_o, output imem_addr_o,
                    input  imem_ack_i, input  imem_data_i);
    modport slave  (input  imem_req_o, input  imem_addr_o,
                    output imem_ack_i, output imem_data_i);
endinterface

// File: rtl/if_perf_cnt.sv
// Fetch/squash event counters; instantiated only when IF_PERF_CNT_EN is defined.
module if_perf_cnt (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_inc_i,
    input  logic        squash_inc_i,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] squash_cnt_o
);
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_squash_cnt;

    // Both counters wrap naturally at 2^32.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_fetch_cnt  <= '0;
            r_squash_cnt <= '0;
        end else begin
            if (fetch_inc_i)  r_fetch_cnt  <= r_fetch_cnt + 32'd1;
            if (squash_inc_i) r_squash_cnt <= r_squash_cnt + 32'd1;
        end
    end

    assign fetch_cnt_o  = r_fetch_cnt;
    assign squash_cnt_o = r_squash_cnt;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, single-outstanding imem request, registered {PC+4, instr} packet.
// Optional IF_PERF_CNT_EN adds fetch/squash counters (if_perf_cnt).
module instr_fetch
    import if_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pcwrite_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    instr_fetch_if.master      imem,
    output logic [ADDR_W+31:0] data_o,
    output logic               valid_o,
    output logic [ADDR_W-1:0]  pc_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt_o,
    output logic [31:0]        squash_cnt_o
`endif
);
    localparam int PKT_W = ADDR_W + 32;

    fetch_state_e      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [ADDR_W-1:0] r_stale_addr, w_stale_nxt;
    logic [PKT_W-1:0]  r_data, w_data_nxt;
    logic              r_valid, w_valid_nxt;

    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_inc;

    assign w_target = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign w_pc_inc = r_pc + ADDR_W'(4);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_stale_addr <= RESET_PC;
            r_data       <= PKT_W'(NOP_PKT);
            r_valid      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_stale_addr <= w_stale_nxt;
            r_data       <= w_data_nxt;
            r_valid      <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_stale_nxt = r_stale_addr;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        unique case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ: begin
                if (redirect_i) begin
                    w_pc_nxt = w_target;
                    // Without an ack the old request stays on the bus until memory answers.
                    if (!imem.imem_ack_i) begin
                        w_state_nxt = DROP;
                        w_stale_nxt = r_pc;
                    end
                end else if (imem.imem_ack_i) begin
                    w_data_nxt  = {w_pc_inc, imem.imem_data_i};
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                if (redirect_i) begin
                    w_pc_nxt    = w_target;
                    w_data_nxt  = PKT_W'(NOP_PKT);
                    w_valid_nxt = 1'b0;
                    w_state_nxt = REQ;
                end else if (pcwrite_i) begin
                    w_data_nxt  = PKT_W'(NOP_PKT);
                    w_valid_nxt = 1'b0;
                    w_state_nxt = REQ;
                end
            end
            DROP: begin
                if (redirect_i) w_pc_nxt = w_target;
                if (imem.imem_ack_i) w_state_nxt = REQ;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign imem.imem_req_o  = (r_state == REQ) || (r_state == DROP);
    assign imem.imem_addr_o = (r_state == DROP) ? r_stale_addr : r_pc;
    assign data_o           = r_data;
    assign valid_o          = r_valid;
    assign pc_o             = r_pc;

`ifdef IF_PERF_CNT_EN
    logic w_fetch_inc;
    logic w_squash_inc;

    assign w_fetch_inc  = (r_state == REQ) && imem.imem_ack_i && !redirect_i;
    assign w_squash_inc = imem.imem_ack_i &&
                          (((r_state == REQ) && redirect_i) || (r_state == DROP));

    if_perf_cnt u_perf_cnt (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .fetch_inc_i  (w_fetch_inc),
        .squash_inc_i (w_squash_inc),
        .fetch_cnt_o  (fetch_cnt_o),
        .squash_cnt_o (squash_cnt_o)
    );
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch (RESET_PC=0x100); counter checks active with IF_PERF_CNT_EN.
module tb_instr_fetch;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        pcwrite_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [63:0] data_o;
    logic        valid_o;
    logic [31:0] pc_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] squash_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_if #(.ADDR_W(32)) imem_bus ();

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0100)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pcwrite_i     (pcwrite_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (imem_bus.master),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .pc_o          (pc_o)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt_o   (fetch_cnt_o),
        .squash_cnt_o  (squash_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        imem_bus.imem_ack_i = 1'b0;
        imem_bus.imem_data_i = '0;
        step(); step();
        n_cmp++; if (imem_bus.imem_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req got %0h want 0", imem_bus.imem_req_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0h want 0", valid_o); end
        n_cmp++; if (data_o !== 64'h0) begin n_err++; $display("FAIL reset_data got %h want 0", data_o); end
        n_cmp++; if (pc_o !== 32'h100) begin n_err++; $display("FAIL reset_pc got %h want 00000100", pc_o); end
        n_cmp++; if (imem_bus.imem_addr_o !== 32'h100) begin n_err++; $display("FAIL reset_addr got %h want 00000100", imem_bus.imem_addr_o); end
`ifdef IF_PERF_CNT_EN
        n_cmp++; if (fetch_cnt_o !== 32'd0 || squash_cnt_o !== 32'd0) begin n_err++; $display("FAIL reset_cnt got %0d/%0d want 0/0", fetch_cnt_o, squash_cnt_o); end
`endif
        rst_i = 1'b1;
        step();
        n_cmp++; if (imem_bus.imem_req_o !== 1'b1 || imem_bus.imem_addr_o !== 32'h100) begin n_err++; $display("FAIL first_req got req=%0h addr=%h want 1/00000100", imem_bus.imem_req_o, imem_bus.imem_addr_o); end
    endtask

    task automatic test_fetch();
        imem_bus.imem_ack_i = 1'b1; imem_bus.imem_data_i = 32'hA0A0_0001;
        step();
        imem_bus.imem_ack_i = 1'b0;
        n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL fetch_valid got %0h want 1", valid_o); end
        n_cmp++; if (data_o !== 64'h0000_0104_A0A0_0001) begin n_err++; $display("FAIL fetch_data got %h want 00000104a0a00001", data_o); end
        n_cmp++; if (imem_bus.imem_req_o !== 1'b0 || pc_o !== 32'h104) begin n_err++; $display("FAIL fetch_full got req=%0h pc=%h want 0/00000104", imem_bus.imem_req_o, pc_o); end
        pcwrite_i = 1'b1;
        step();
        pcwrite_i = 1'b0;
        n_cmp++; if (valid_o !== 1'b0 || imem_bus.imem_req_o !== 1'b1 || imem_bus.imem_addr_o !== 32'h104) begin n_err++; $display("FAIL fetch_next got v=%0h req=%0h addr=%h want 0/1/00000104", valid_o, imem_bus.imem_req_o, imem_bus.imem_addr_o); end
    endtask

    task automatic test_stall();
        imem_bus.imem_ack_i = 1'b1; imem_bus.imem_data_i = 32'hB0B0_0002;
        step();
        imem_bus.imem_ack_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            // An ack arriving while full must be ignored.
            imem_bus.imem_ack_i = (i == 2); imem_bus.imem_data_i = 32'hDEAD_BEEF;
            step();
            n_cmp++; if (data_o !== 64'h0000_0108_B0B0_0002 || valid_o !== 1'b1) begin n_err++; $display("FAIL stall_data[%0d] got v=%0h d=%h want 1/00000108b0b00002", i, valid_o, data_o); end
            n_cmp++; if (pc_o !== 32'h108 || imem_bus.imem_req_o !== 1'b0) begin n_err++; $display("FAIL stall_pc[%0d] got pc=%h req=%0h want 00000108/0", i, pc_o, imem_bus.imem_req_o); end
        end
        imem_bus.imem_ack_i = 1'b0;
        pcwrite_i = 1'b1;
        step();
        pcwrite_i = 1'b0;
        n_cmp++; if (imem_bus.imem_req_o !== 1'b1 || imem_bus.imem_addr_o !== 32'h108 || valid_o !== 1'b0) begin n_err++; $display("FAIL stall_release got req=%0h addr=%h v=%0h want 1/00000108/0", imem_bus.imem_req_o, imem_bus.imem_addr_o, valid_o); end
    endtask

    task automatic test_redirect_outstanding();
        step();
        redirect_i = 1'b1; redirect_pc_i = 32'h200;
        step();
        redirect_i = 1'b0;
        n_cmp++; if (imem_bus.imem_req_o !== 1'b1 || imem_bus.imem_addr_o !== 32'h108) begin n_err++; $display("FAIL drop_hold got req=%0h addr=%h want 1/00000108", imem_bus.imem_req_o, imem_bus.imem_addr_o); end
        n_cmp++; if (pc_o !== 32'h200) begin n_err++; $display("FAIL drop_pc got %h want 00000200", pc_o); end
        step();
        n_cmp++; if (valid_o !== 1'b0 || imem_bus.imem_addr_o !== 32'h108) begin n_err++; $display("FAIL drop_wait got v=%0h addr=%h want 0/00000108", valid_o, imem_bus.imem_addr_o); end
        imem_bus.imem_ack_i = 1'b1; imem_bus.imem_data_i = 32'h57A1_E000;
        step();
        imem_bus.imem_ack_i = 1'b0;
        n_cmp++; if (valid_o !== 1'b0 || data_o !== 64'h0) begin n_err++; $display("FAIL drop_discard got v=%0h d=%h want 0/0", valid_o, data_o); end
        n_cmp++; if (imem_bus.imem_req_o !== 1'b1 || imem_bus.imem_addr_o !== 32'h200) begin n_err++; $display("FAIL drop_newreq got req=%0h addr=%h want 1/00000200", imem_bus.imem_req_o, imem_bus.imem_addr_o); end
`ifdef IF_PERF_CNT_EN
        n_cmp++; if (squash_cnt_o !== 32'd1) begin n_err++; $display("FAIL drop_squash_cnt got %0d want 1", squash_cnt_o); end
`endif
    endtask

    task automatic test_redirect_ack_same();
        redirect_i = 1'b1; redirect_pc_i = 32'h400;
        imem_bus.imem_ack_i = 1'b1; imem_bus.imem_data_i = 32'h57A1_E001;
        step();
        redirect_i = 1'b0; imem_bus.imem_ack_i = 1'b0;
        n_cmp++; if (valid_o !== 1'b0 || imem_bus.imem_req_o !== 1'b1 || imem_bus.imem_addr_o !== 32'h400) begin n_err++; $display("FAIL same_cycle got v=%0h req=%0h addr=%h want 0/1/00000400", valid_o, imem_bus.imem_req_o, imem_bus.imem_addr_o); end
`ifdef IF_PERF_CNT_EN
        n_cmp++; if (squash_cnt_o !== 32'd2) begin n_err++; $display("FAIL same_squash_cnt got %0d want 2", squash_cnt_o); end
`endif
    endtask

    task automatic test_redirect_full();
        imem_bus.imem_ack_i = 1'b1; imem_bus.imem_data_i = 32'hC0C0_0003;
        step();
        imem_bus.imem_ack_i = 1'b0;
        n_cmp++; if (data_o !== 64'h0000_0404_C0C0_0003) begin n_err++; $display("FAIL full_load got %h want 00000404c0c00003", data_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'h500; pcwrite_i = 1'b1;
        step();
        redirect_i = 1'b0; pcwrite_i = 1'b0;
        n_cmp++; if (valid_o !== 1'b0 || data_o !== 64'h0) begin n_err++; $display("FAIL full_redir_clear got v=%0h d=%h want 0/0", valid_o, data_o); end
        n_cmp++; if (pc_o !== 32'h500 || imem_bus.imem_addr_o !== 32'h500 || imem_bus.imem_req_o !== 1'b1) begin n_err++; $display("FAIL full_redir_req got pc=%h addr=%h req=%0h want 00000500/00000500/1", pc_o, imem_bus.imem_addr_o, imem_bus.imem_req_o); end
        step();
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL full_no_redeliver got v=%0h want 0", valid_o); end
    endtask

    task automatic test_wrap();
        // Same-cycle redirect+ack keeps REQ; target low bits are cleared.
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF; imem_bus.imem_ack_i = 1'b1;
        step();
        redirect_i = 1'b0;
        n_cmp++; if (imem_bus.imem_addr_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_align got %h want fffffffc", imem_bus.imem_addr_o); end
        imem_bus.imem_data_i = 32'hD0D0_0004;
        step();
        imem_bus.imem_ack_i = 1'b0;
        n_cmp++; if (data_o !== 64'h0000_0000_D0D0_0004 || pc_o !== 32'h0) begin n_err++; $display("FAIL wrap_pkt got d=%h pc=%h want 00000000d0d00004/0", data_o, pc_o); end
        pcwrite_i = 1'b1;
        step();
        pcwrite_i = 1'b0;
        n_cmp++; if (imem_bus.imem_addr_o !== 32'h0 || imem_bus.imem_req_o !== 1'b1) begin n_err++; $display("FAIL wrap_next got addr=%h req=%0h want 0/1", imem_bus.imem_addr_o, imem_bus.imem_req_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'h203; imem_bus.imem_ack_i = 1'b1;
        step();
        redirect_i = 1'b0;
        n_cmp++; if (imem_bus.imem_addr_o !== 32'h200) begin n_err++; $display("FAIL redir_align got %h want 00000200", imem_bus.imem_addr_o); end
        imem_bus.imem_data_i = 32'hE0E0_0005;
        step();
        imem_bus.imem_ack_i = 1'b0;
        n_cmp++; if (data_o !== 64'h0000_0204_E0E0_0005) begin n_err++; $display("FAIL redir_pkt got %h want 00000204e0e00005", data_o); end
`ifdef IF_PERF_CNT_EN
        n_cmp++; if (fetch_cnt_o !== 32'd5 || squash_cnt_o !== 32'd4) begin n_err++; $display("FAIL wrap_cnt got %0d/%0d want 5/4", fetch_cnt_o, squash_cnt_o); end
`endif
    endtask

    task automatic test_reset_mid();
        pcwrite_i = 1'b1;
        step();
        pcwrite_i = 1'b0;
        rst_i = 1'b0;
        #1;
        n_cmp++; if (imem_bus.imem_req_o !== 1'b0 || pc_o !== 32'h100 || valid_o !== 1'b0) begin n_err++; $display("FAIL mid_reset got req=%0h pc=%h v=%0h want 0/00000100/0", imem_bus.imem_req_o, pc_o, valid_o); end
        step();
        rst_i = 1'b1;
        // Ack while IDLE must not load a packet.
        imem_bus.imem_ack_i = 1'b1; imem_bus.imem_data_i = 32'hBAD0_0006;
        step();
        imem_bus.imem_ack_i = 1'b0;
        n_cmp++; if (valid_o !== 1'b0 || imem_bus.imem_req_o !== 1'b1 || imem_bus.imem_addr_o !== 32'h100) begin n_err++; $display("FAIL idle_ack got v=%0h req=%0h addr=%h want 0/1/00000100", valid_o, imem_bus.imem_req_o, imem_bus.imem_addr_o); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_redirect_outstanding();
        test_redirect_ack_same();
        test_redirect_full();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register. Holds the program counter, issues one request at a time to instruction memory over a req/ack handshake, and presents a registered 64-bit fetch packet {PC+4, instruction} with a valid flag. Accepts stall and branch redirect from the hazard and branch units, and discards in-flight fetches that a redirect has made stale.

## Interface
- ADDR_W, 32, PC and memory address width; packet upper half is ADDR_W bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- pcwrite_i  in  1  consumer accepts packet this cycle (drives IF/ID write enable in parallel).
- redirect_i  in  1  branch/jump taken; overrides everything else.
- redirect_pc_i  in  ADDR_W  redirect target; bits [1:0] ignored and forced to 0.
- imem_req_o  out  1  fetch request, held until ack.
- imem_addr_o  out  ADDR_W  fetch address, stable while imem_req_o=1.
- imem_ack_i  in  1  memory returns imem_data_i this cycle.
- imem_data_i  in  32  instruction word.
- data_o  out  64  [63:32] = fetched PC+4, [31:0] = instruction; registered.
- valid_o  out  1  data_o holds an undelivered instruction.
- pc_o  out  ADDR_W  current PC register (debug).

## Operation
- States: IDLE, REQ, FULL, DROP. Reset: state=IDLE, pc=RESET_PC, data_o=0, valid_o=0; imem_req_o=0 (decoded from state), imem_addr_o=pc.
- imem_req_o=1 in REQ and DROP only. imem_addr_o=pc in REQ; in DROP it holds the address of the stale request until ack.
- IDLE: next cycle -> REQ unconditionally.
- REQ: redirect_i -> pc=target; if ack same cycle, discard data, stay REQ (new request at target next cycle); if no ack -> DROP. ack without redirect -> data_o={pc+4, imem_data_i}, valid_o=1, pc=pc+4 -> FULL.
- FULL: redirect_i -> valid_o=0, data_o=0, pc=target -> REQ. Else pcwrite_i -> valid_o=0, data_o=0 -> REQ. Else hold (data_o, valid_o, pc stable).
- DROP: redirect_i -> pc=latest target (last redirect wins). ack -> discard data -> REQ. No ack -> stay DROP.
- Priority in every state: reset > redirect_i > imem_ack_i > pcwrite_i.
- pcwrite_i is ignored when valid_o=0; imem_ack_i is ignored in IDLE and FULL.
- PC arithmetic is modulo 2^ADDR_W: 0xFFFF_FFFC+4 = 0x0000_0000. No misalignment trap; low bits are always 0.
- Reset asserted mid-request: immediate return to reset values; a later ack from memory is ignored in IDLE.

## Timing
- Earliest ack: same cycle req is first asserted. Fetch latency = ack latency +1 cycle to valid_o.
- Zero-wait memory gives a peak throughput of one packet per 2 cycles (REQ, FULL alternating).
- Redirect to first request at the new target: 1 cycle from REQ or FULL; from DROP, 1 cycle after the stale ack.
- data_o/valid_o change only on clock edges; no combinational path from inputs to data_o.

## Configuration
- IF_PERF_CNT_EN defined: adds outputs fetch_cnt_o[31:0] (packets loaded into data_o) and squash_cnt_o[31:0] (acks discarded in REQ-with-redirect or DROP). Both reset to 0, wrap at 2^32, and increment by at most 1 per cycle.
- Undefined: ports and counters are absent; fetch behaviour is identical.

## Structure
- Shared package if_pkg: fetch state enum (IDLE/REQ/FULL/DROP), FETCH_PKT_W=64, NOP packet constant (all zeros), default RESET_PC.
- One sub-module: if_perf_cnt (the two counters), instantiated only under IF_PERF_CNT_EN. FSM, PC and packet register stay in instr_fetch.

## Test plan
- Reset release, RESET_PC=0x100, ack latency 0: req seen with addr 0x100; next cycle valid_o=1, data_o={0x104, word}; pcwrite_i=1 -> next addr 0x104.
- Stall: valid_o=1 with pcwrite_i=0 for 5 cycles -> data_o, pc_o unchanged and imem_req_o=0 throughout; release -> request at next PC.
- Redirect while outstanding (ack latency 3, redirect to 0x200 in cycle 1): stale ack discarded, valid_o stays 0, next request addr 0x200; squash_cnt_o=1 when enabled.
- Redirect and ack in the same cycle: data discarded, next cycle req at target, valid_o=0.
- Redirect in FULL with pcwrite_i=1: valid_o cleared, pc=target, buffered packet is not delivered twice.
- Wrap: PC 0xFFFF_FFFC fetched -> data_o[63:32]=0x0, next addr 0x0; redirect_pc_i=0x203 -> fetch addr 0x200.
